// File: rtl/sar_search_controller_pkg.sv
// Shared state encoding and verdict helper for the successive-approximation controller.
package sar_search_controller_pkg;

  typedef enum logic [1:0] {
    SAR_IDLE = 2'd0,
    SAR_TEST = 2'd1,
    SAR_DONE = 2'd2
  } sar_state_e;

  // A comparator verdict is only trustworthy when exactly one line is high.
  function automatic logic sar_onehot3(input logic gt, input logic eq, input logic lt);
    return (gt & ~eq & ~lt) | (~gt & eq & ~lt) | (~gt & ~eq & lt);
  endfunction

endpackage

// File: rtl/sar_search_controller.sv
// MSB-first successive-approximation search driving an external magnitude comparator,
// with a per-trial settle delay and early exit on equality.
module sar_search_controller
  import sar_search_controller_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       cmp_gt,
  input  logic                       cmp_eq,
  input  logic                       cmp_lt,
  output logic [WIDTH-1:0]           trial,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           result,
  output logic                       err,
  output logic [$clog2(WIDTH+1)-1:0] steps
);

  localparam int SW = $clog2(WIDTH + 1);
  localparam int BW = $clog2(WIDTH);
  localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  sar_state_e        state_q, state_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  trial_q, trial_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic [SW-1:0]     steps_q, steps_d;
  logic              err_q, err_d;

  logic [WIDTH-1:0]  bit_mask;
  logic [WIDTH-1:0]  acc_upd;
  logic              verdict_ok;

  assign bit_mask   = {{(WIDTH-1){1'b0}}, 1'b1} << bit_q;
  assign acc_upd    = cmp_gt ? (acc_q | bit_mask) : (acc_q & ~bit_mask);
  assign verdict_ok = sar_onehot3(cmp_gt, cmp_eq, cmp_lt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SAR_IDLE;
      acc_q    <= '0;
      trial_q  <= '0;
      result_q <= '0;
      bit_q    <= '0;
      wcnt_q   <= '0;
      steps_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      bit_q    <= bit_d;
      wcnt_q   <= wcnt_d;
      steps_q  <= steps_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    trial_d  = trial_q;
    result_d = result_q;
    bit_d    = bit_q;
    wcnt_d   = wcnt_q;
    steps_d  = steps_q;
    err_d    = err_q;
    case (state_q)
      SAR_IDLE: begin
        if (start) begin
          acc_d   = '0;
          bit_d   = BW'(WIDTH - 1);
          wcnt_d  = CW'(SETTLE);
          trial_d = {1'b1, {(WIDTH-1){1'b0}}};
          steps_d = '0;
          err_d   = 1'b0;
          state_d = SAR_TEST;
        end
      end
      SAR_TEST: begin
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - CW'(1);
        end else begin
          steps_d = steps_q + SW'(1);
          if (!verdict_ok) begin
            err_d    = 1'b1;
            result_d = trial_q;
            state_d  = SAR_DONE;
          end else if (cmp_eq) begin
            result_d = trial_q;
            state_d  = SAR_DONE;
          end else begin
            acc_d = acc_upd;
            if (bit_q == '0) begin
              result_d = acc_upd;
              state_d  = SAR_DONE;
            end else begin
              // Next trial tentatively sets the next-lower bit on top of the kept bits.
              bit_d   = bit_q - BW'(1);
              trial_d = acc_upd | (bit_mask >> 1);
              wcnt_d  = CW'(SETTLE);
            end
          end
        end
      end
      SAR_DONE: state_d = SAR_IDLE;
      default:  state_d = SAR_IDLE;
    endcase
  end

  assign trial  = trial_q;
  assign busy   = (state_q == SAR_TEST);
  assign done   = (state_q == SAR_DONE);
  assign result = result_q;
  assign err    = err_q;
  assign steps  = steps_q;

endmodule
